bank_host_responder: RTL and testbench

Bank-side responder for the ATM's account requests; the ATM front-end is the initiator, this block is the host that owns the account, PIN and balance tables.
- Accepts one request at a time over a valid/ready handshake.
- Scans the account table sequentially, then executes the operation.
- Returns a status code and the resulting balance over a second valid/ready handshake.

---
 rtl/bank_host_responder.sv | 244 ++++++++++++++++++++++++
 tb/tb_bank_host_responder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/bank_host_responder.sv
// bank_host_responder: bank-side host for ATM account requests.
// Accepts one request over req_valid/req_ready, scans the account table one
// entry per cycle (fixed NUM_ACCOUNTS-cycle lookup), executes the operation
// in a single cycle and returns status + source balance over
// resp_valid/resp_ready.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake
//   req_op/acc/pin/dst/amount request fields, sampled only at acceptance
//   resp_valid/resp_ready    response handshake
//   resp_status/resp_balance response fields, held until taken
//
// Optional feature: define BANK_LOCKOUT_EN to add per-account wrong-PIN
// counters that lock an account after MAX_PIN_FAILS consecutive failures.
module bank_host_responder #(
  parameter int unsigned NUM_ACCOUNTS  = 10,
  parameter int unsigned BAL_W         = 16,
  parameter int unsigned INIT_BALANCE  = 500,
  parameter int unsigned MAX_PIN_FAILS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [11:0]      req_acc,
  input  logic [3:0]       req_pin,
  input  logic [11:0]      req_dst,
  input  logic [BAL_W-1:0] req_amount,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [2:0]       resp_status,
  output logic [BAL_W-1:0] resp_balance
);

  localparam int unsigned IDX_W = 4;
  localparam int unsigned SUM_W = BAL_W + 1;

  localparam logic [2:0] OP_AUTH     = 3'd0;
  localparam logic [2:0] OP_WITHDRAW = 3'd2;
  localparam logic [2:0] OP_DEPOSIT  = 3'd3;
  localparam logic [2:0] OP_TRANSFER = 3'd4;

  localparam logic [2:0] ST_OK           = 3'd0;
  localparam logic [2:0] ST_NO_ACCOUNT   = 3'd1;
  localparam logic [2:0] ST_BAD_PIN      = 3'd2;
  localparam logic [2:0] ST_INSUFFICIENT = 3'd3;
  localparam logic [2:0] ST_OVERFLOW     = 3'd4;
  localparam logic [2:0] ST_NO_DEST      = 3'd5;
  localparam logic [2:0] ST_BAD_OP       = 3'd6;
  localparam logic [2:0] ST_LOCKED       = 3'd7;

  typedef enum logic [1:0] {IDLE, LOOKUP, EXEC, RESP} state_t;

  // Elaboration-time sanity check of the configuration.
  if (NUM_ACCOUNTS == 0 || NUM_ACCOUNTS > 16 || MAX_PIN_FAILS == 0) begin : g_bad_cfg
    $error("bank_host_responder: unsupported NUM_ACCOUNTS or MAX_PIN_FAILS");
  end

  // Fixed account-number table; entries past the ten defined accounts get
  // numbers 3010.. so they never alias a real account.
  function automatic logic [11:0] acct_num(input logic [IDX_W-1:0] i);
    case (i)
      4'd0:    acct_num = 12'd2749;
      4'd1:    acct_num = 12'd2175;
      4'd2:    acct_num = 12'd2429;
      4'd3:    acct_num = 12'd2125;
      4'd4:    acct_num = 12'd2178;
      4'd5:    acct_num = 12'd2647;
      4'd6:    acct_num = 12'd2816;
      4'd7:    acct_num = 12'd2910;
      4'd8:    acct_num = 12'd2299;
      4'd9:    acct_num = 12'd2689;
      default: acct_num = 12'd3000 + {8'd0, i};
    endcase
  endfunction

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [2:0]       r_op;
  logic [11:0]      r_acc;
  logic [3:0]       r_pin;
  logic [11:0]      r_dst;
  logic [BAL_W-1:0] r_amount;
  logic             src_found, dst_found;
  logic [IDX_W-1:0] src_idx, dst_idx;
  logic [BAL_W-1:0] bal [NUM_ACCOUNTS];

`ifdef BANK_LOCKOUT_EN
  localparam int unsigned CNT_W = $clog2(MAX_PIN_FAILS + 1);
  logic [CNT_W-1:0] fail_cnt [NUM_ACCOUNTS];
`endif

  logic [BAL_W-1:0] src_bal_c, dst_bal_c, new_src_c, new_dst_c, exec_bal_c;
  logic [SUM_W-1:0] src_sum_c, dst_sum_c;
  logic [2:0]       exec_status_c;
  logic             pin_ok_c, locked_c, pin_checked_c;

  // Operation decision for the EXEC cycle, first failing check wins.
  always_comb begin
    src_bal_c     = bal[src_idx];
    dst_bal_c     = bal[dst_idx];
    src_sum_c     = {1'b0, src_bal_c} + {1'b0, r_amount};
    dst_sum_c     = {1'b0, dst_bal_c} + {1'b0, r_amount};
    pin_ok_c      = (r_pin == src_idx);
    locked_c      = 1'b0;
`ifdef BANK_LOCKOUT_EN
    locked_c      = (fail_cnt[src_idx] == CNT_W'(MAX_PIN_FAILS));
`endif
    pin_checked_c = 1'b0;
    exec_status_c = ST_OK;
    if (r_op > OP_TRANSFER) begin
      exec_status_c = ST_BAD_OP;
    end else if (!src_found) begin
      exec_status_c = ST_NO_ACCOUNT;
    end else if (locked_c) begin
      exec_status_c = ST_LOCKED;
    end else begin
      pin_checked_c = 1'b1;
      if (!pin_ok_c) begin
        exec_status_c = ST_BAD_PIN;
      end else if (r_op == OP_TRANSFER && (!dst_found || dst_idx == src_idx)) begin
        exec_status_c = ST_NO_DEST;
      end else if ((r_op == OP_WITHDRAW || r_op == OP_TRANSFER) && r_amount > src_bal_c) begin
        exec_status_c = ST_INSUFFICIENT;
      end else if ((r_op == OP_DEPOSIT && src_sum_c[BAL_W]) ||
                   (r_op == OP_TRANSFER && dst_sum_c[BAL_W])) begin
        exec_status_c = ST_OVERFLOW;
      end
    end

    new_src_c = src_bal_c;
    new_dst_c = dst_bal_c;
    if (exec_status_c == ST_OK) begin
      case (r_op)
        OP_WITHDRAW: new_src_c = src_bal_c - r_amount;
        OP_DEPOSIT:  new_src_c = src_sum_c[BAL_W-1:0];
        OP_TRANSFER: begin
          new_src_c = src_bal_c - r_amount;
          new_dst_c = dst_sum_c[BAL_W-1:0];
        end
        default: ;
      endcase
    end

    if (exec_status_c == ST_BAD_OP || exec_status_c == ST_NO_ACCOUNT)
      exec_bal_c = '0;
    else
      exec_bal_c = new_src_c;
  end

  // Control FSM, request capture, table scan and balance updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_status  <= '0;
      resp_balance <= '0;
      idx          <= '0;
      r_op         <= '0;
      r_acc        <= '0;
      r_pin        <= '0;
      r_dst        <= '0;
      r_amount     <= '0;
      src_found    <= 1'b0;
      dst_found    <= 1'b0;
      src_idx      <= '0;
      dst_idx      <= '0;
      for (int i = 0; i < int'(NUM_ACCOUNTS); i++) begin
        bal[i] <= BAL_W'(INIT_BALANCE);
`ifdef BANK_LOCKOUT_EN
        fail_cnt[i] <= '0;
`endif
      end
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            r_op      <= req_op;
            r_acc     <= req_acc;
            r_pin     <= req_pin;
            r_dst     <= req_dst;
            r_amount  <= req_amount;
            src_found <= 1'b0;
            dst_found <= 1'b0;
            src_idx   <= '0;
            dst_idx   <= '0;
            idx       <= '0;
            req_ready <= 1'b0;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          // Keep only the first match; scan always covers the full table.
          if (!src_found && acct_num(idx) == r_acc) begin
            src_found <= 1'b1;
            src_idx   <= idx;
          end
          if (!dst_found && acct_num(idx) == r_dst) begin
            dst_found <= 1'b1;
            dst_idx   <= idx;
          end
          if (idx == IDX_W'(NUM_ACCOUNTS - 1)) state <= EXEC;
          else                                 idx   <= idx + 4'd1;
        end
        EXEC: begin
          resp_status  <= exec_status_c;
          resp_balance <= exec_bal_c;
          resp_valid   <= 1'b1;
          state        <= RESP;
          if (exec_status_c == ST_OK && r_op != OP_AUTH) begin
            bal[src_idx] <= new_src_c;
            if (r_op == OP_TRANSFER) bal[dst_idx] <= new_dst_c;
          end
`ifdef BANK_LOCKOUT_EN
          if (pin_checked_c) begin
            if (pin_ok_c)
              fail_cnt[src_idx] <= '0;
            else if (fail_cnt[src_idx] != CNT_W'(MAX_PIN_FAILS))
              fail_cnt[src_idx] <= fail_cnt[src_idx] + CNT_W'(1);
          end
`endif
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef BANK_LOCKOUT_EN
  // Only consumed by the lockout counters.
  logic unused_c;
  assign unused_c = pin_checked_c;
`endif

endmodule

// File: tb/tb_bank_host_responder.sv
module tb_bank_host_responder;

  localparam int unsigned BAL_W = 16;

  localparam logic [2:0] OP_AUTH = 3'd0, OP_BAL = 3'd1, OP_WD = 3'd2,
                         OP_DEP = 3'd3, OP_TR = 3'd4;
  localparam logic [2:0] S_OK = 3'd0, S_NOACC = 3'd1, S_BADPIN = 3'd2,
                         S_INSUF = 3'd3, S_OVF = 3'd4, S_NODEST = 3'd5,
                         S_BADOP = 3'd6, S_LOCKED = 3'd7;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [11:0]      req_acc;
  logic [3:0]       req_pin;
  logic [11:0]      req_dst;
  logic [BAL_W-1:0] req_amount;
  logic             resp_valid;
  logic             resp_ready;
  logic [2:0]       resp_status;
  logic [BAL_W-1:0] resp_balance;

  int n_checks = 0;
  int n_errors = 0;

  bank_host_responder dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_acc      (req_acc),
    .req_pin      (req_pin),
    .req_dst      (req_dst),
    .req_amount   (req_amount),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_status  (resp_status),
    .resp_balance (resp_balance)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present a request and hold it for exactly the acceptance edge, then scramble fields.
  task automatic send(input logic [2:0] op, input logic [11:0] acc, input logic [3:0] pin,
                      input logic [11:0] dst, input logic [BAL_W-1:0] amt);
    @(negedge clk);
    chk("req_ready_before_accept", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_op     = op;
    req_acc    = acc;
    req_pin    = pin;
    req_dst    = dst;
    req_amount = amt;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_op     = 3'd7;
    req_acc    = 12'd0;
    req_pin    = 4'd15;
    req_dst    = 12'd0;
    req_amount = '1;
  endtask

  // Wait for the response; it must appear exactly 12 cycles after acceptance.
  task automatic wait_resp(input string tag, input logic [2:0] st, input logic [BAL_W-1:0] b);
    int  cnt;
    logic rdy_low;
    cnt = 0;
    rdy_low = 1'b1;
    do begin
      @(negedge clk);
      cnt++;
      if (req_ready) rdy_low = 1'b0;
    end while (!resp_valid && cnt < 40);
    chk({tag, "_latency"}, 32'(cnt), 32'd12);
    chk({tag, "_ready_low"}, 32'(rdy_low), 32'd1);
    chk({tag, "_status"}, 32'(resp_status), 32'(st));
    chk({tag, "_balance"}, 32'(resp_balance), 32'(b));
  endtask

  task automatic take_resp(input string tag);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_valid_drop"}, 32'(resp_valid), 32'd0);
    chk({tag, "_ready_back"}, 32'(req_ready), 32'd1);
  endtask

  task automatic do_req(input string tag, input logic [2:0] op, input logic [11:0] acc,
                        input logic [3:0] pin, input logic [11:0] dst,
                        input logic [BAL_W-1:0] amt, input logic [2:0] st,
                        input logic [BAL_W-1:0] b);
    send(op, acc, pin, dst, amt);
    wait_resp(tag, st, b);
    take_resp(tag);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_resp_status"}, 32'(resp_status), 32'd0);
    chk({tag, "_resp_balance"}, 32'(resp_balance), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]       hold_st;
    logic [BAL_W-1:0] hold_bal;
    logic             stable, no_accept;

    rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
    req_op = '0; req_acc = '0; req_pin = '0; req_dst = '0; req_amount = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;

    do_req("auth",       OP_AUTH, 12'd2175, 4'd1, 12'd0,    16'd0,     S_OK,     16'd500);
    do_req("wd200",      OP_WD,   12'd2749, 4'd0, 12'd0,    16'd200,   S_OK,     16'd300);
    do_req("wd301",      OP_WD,   12'd2749, 4'd0, 12'd0,    16'd301,   S_INSUF,  16'd300);
    do_req("wd0",        OP_WD,   12'd2749, 4'd0, 12'd0,    16'd0,     S_OK,     16'd300);
    do_req("badpin",     OP_BAL,  12'd2749, 4'd5, 12'd0,    16'd0,     S_BADPIN, 16'd300);
    do_req("tr150",      OP_TR,   12'd2429, 4'd2, 12'd2910, 16'd150,   S_OK,     16'd350);
    do_req("bal_dst",    OP_BAL,  12'd2910, 4'd7, 12'd0,    16'd0,     S_OK,     16'd650);
    do_req("tr_nodst",   OP_TR,   12'd2429, 4'd2, 12'd1234, 16'd10,    S_NODEST, 16'd350);
    do_req("tr_self",    OP_TR,   12'd2429, 4'd2, 12'd2429, 16'd10,    S_NODEST, 16'd350);
    do_req("dep_max",    OP_DEP,  12'd2125, 4'd3, 12'd0,    16'd65035, S_OK,     16'd65535);
    do_req("dep_ovf",    OP_DEP,  12'd2125, 4'd3, 12'd0,    16'd1,     S_OVF,    16'd65535);
    do_req("tr_ovf",     OP_TR,   12'd2429, 4'd2, 12'd2125, 16'd1,     S_OVF,    16'd350);
    do_req("tr_insuf",   OP_TR,   12'd2429, 4'd2, 12'd2910, 16'd351,   S_INSUF,  16'd350);
    do_req("badop",      3'd6,    12'd2125, 4'd3, 12'd0,    16'd0,     S_BADOP,  16'd0);
    do_req("noacc",      OP_BAL,  12'd1111, 4'd0, 12'd0,    16'd0,     S_NOACC,  16'd0);
    do_req("bal_src",    OP_BAL,  12'd2429, 4'd2, 12'd0,    16'd0,     S_OK,     16'd350);

    // Backpressure: response held for 5 cycles while another request is offered.
    send(OP_WD, 12'd2178, 4'd4, 12'd0, 16'd40);
    wait_resp("stall", S_OK, 16'd460);
    hold_st = resp_status; hold_bal = resp_balance;
    stable = 1'b1; no_accept = 1'b1;
    req_valid = 1'b1; req_op = OP_DEP; req_acc = 12'd2178; req_pin = 4'd4; req_amount = 16'd7;
    repeat (5) begin
      @(negedge clk);
      if (!resp_valid || resp_status !== hold_st || resp_balance !== hold_bal) stable = 1'b0;
      if (req_ready) no_accept = 1'b0;
    end
    req_valid = 1'b0;
    chk("stall_stable", 32'(stable), 32'd1);
    chk("stall_no_accept", 32'(no_accept), 32'd1);
    take_resp("stall");
    do_req("stall_after", OP_BAL, 12'd2178, 4'd4, 12'd0, 16'd0, S_OK, 16'd460);

    // Reset during LOOKUP discards the withdraw and reloads the table.
    send(OP_WD, 12'd2749, 4'd0, 12'd0, 16'd100);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midrst");
    rst = 1'b0;
    do_req("midrst_bal",  OP_BAL, 12'd2749, 4'd0, 12'd0, 16'd0, S_OK, 16'd500);
    do_req("midrst_bal2", OP_BAL, 12'd2910, 4'd7, 12'd0, 16'd0, S_OK, 16'd500);

    // Wrong-PIN sequence; outcome of the correct PIN depends on lockout.
    do_req("pinfail1", OP_BAL, 12'd2647, 4'd9, 12'd0, 16'd0, S_BADPIN, 16'd500);
    do_req("pinfail2", OP_BAL, 12'd2647, 4'd9, 12'd0, 16'd0, S_BADPIN, 16'd500);
    do_req("pinfail3", OP_BAL, 12'd2647, 4'd9, 12'd0, 16'd0, S_BADPIN, 16'd500);
`ifdef BANK_LOCKOUT_EN
    do_req("locked",   OP_BAL, 12'd2647, 4'd5, 12'd0, 16'd0, S_LOCKED, 16'd500);
`else
    do_req("unlocked", OP_BAL, 12'd2647, 4'd5, 12'd0, 16'd0, S_OK,     16'd500);
`endif
    do_req("tr_into_2647", OP_TR, 12'd2816, 4'd6, 12'd2647, 16'd10, S_OK, 16'd490);

    // Two wrong PINs then a correct one must clear the count in either build.
    do_req("pinfail_b1", OP_BAL, 12'd2689, 4'd1, 12'd0, 16'd0, S_BADPIN, 16'd500);
    do_req("pinfail_b2", OP_BAL, 12'd2689, 4'd1, 12'd0, 16'd0, S_BADPIN, 16'd500);
    do_req("pinok_b",    OP_BAL, 12'd2689, 4'd9, 12'd0, 16'd0, S_OK,     16'd500);
    do_req("pinfail_b3", OP_BAL, 12'd2689, 4'd1, 12'd0, 16'd0, S_BADPIN, 16'd500);
    do_req("pinok_b2",   OP_BAL, 12'd2689, 4'd9, 12'd0, 16'd0, S_OK,     16'd500);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
